// File: rtl/sisc_exec_core.sv
// sisc_exec_core: execute stage and control FSM for the SISC processor.
// Holds a combinational ALU with {C,V,N,Z} flags, the branch-target adder and
// the multi-cycle control sequencer.
// Optional feature macro: SISC_SWP_EN enables the SWP (register swap) opcode.
// Without it, opcode 5 executes as a NOP and swp_sel stays at 1.
module sisc_exec_core (
  input  logic        clk,
  input  logic        rst_f,
  input  logic [31:0] instr,
  input  logic [31:0] rsa,
  input  logic [31:0] rsb,
  input  logic [3:0]  stat,
  input  logic [15:0] pc_out,
  output logic [31:0] alu_result,
  output logic [3:0]  stat_next,
  output logic        stat_en,
  output logic [15:0] br_addr,
  output logic        rf_we,
  output logic [1:0]  alu_op,
  output logic [1:0]  wb_sel,
  output logic        br_sel,
  output logic        pc_rst,
  output logic        pc_write,
  output logic        pc_sel,
  output logic        rb_sel,
  output logic        ir_load,
  output logic        mm_sel,
  output logic        dm_we,
  output logic        swp_sel
);

  localparam logic [2:0] S_RESET   = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_DECODE  = 3'd3;
  localparam logic [2:0] S_EXECUTE = 3'd4;
  localparam logic [2:0] S_MEM     = 3'd5;
  localparam logic [2:0] S_WB      = 3'd6;
  localparam logic [2:0] S_WB2     = 3'd7;

  localparam logic [3:0] OP_ALUR = 4'h1;
  localparam logic [3:0] OP_ALUI = 4'h2;
  localparam logic [3:0] OP_LOD  = 4'h3;
  localparam logic [3:0] OP_STR  = 4'h4;
  localparam logic [3:0] OP_SWP  = 4'h5;
  localparam logic [3:0] OP_BRA  = 4'h6;
  localparam logic [3:0] OP_BRR  = 4'h7;
  localparam logic [3:0] OP_BNE  = 4'h8;
  localparam logic [3:0] OP_BNR  = 4'h9;
  localparam logic [3:0] OP_HLT  = 4'hF;

  logic [2:0]         state, state_nxt;
  logic [3:0]         op, mm;
  logic [15:0]        imm;
  logic signed [31:0] imm_sx;
  logic [31:0]        op_b;
  logic [32:0]        sum_c, dif_c;
  logic               is_add, is_sub;
  logic               taken, is_swp, is_mem, in_window;
  logic               unused_fields;

  assign op     = instr[31:28];
  assign mm     = instr[27:24];
  assign imm    = instr[15:0];
  assign imm_sx = {{16{imm[15]}}, imm};
  assign is_mem = (op == OP_LOD) || (op == OP_STR);
  // rd/rs select fields are consumed by the register file, not here
  assign unused_fields = ^instr[23:16];

`ifdef SISC_SWP_EN
  assign is_swp = (op == OP_SWP);
`else
  assign is_swp = 1'b0;
`endif

  // Relative targets add to the already-incremented PC; wraps at 16 bits
  assign br_addr = br_sel ? imm : (pc_out + imm);

  // ALU: operand B select, function select and flag generation
  always_comb begin
    op_b = rsb;
    case (alu_op)
      2'b01:   op_b = imm_sx;
      2'b10:   op_b = {16'h0000, imm};
      default: op_b = rsb;
    endcase
    sum_c      = {1'b0, rsa} + {1'b0, op_b};
    dif_c      = {1'b0, rsa} + {1'b0, ~op_b} + 33'd1;
    is_add     = 1'b0;
    is_sub     = 1'b0;
    alu_result = '0;
    case (alu_op)
      2'b11: alu_result = rsa;
      2'b10: begin
        alu_result = sum_c[31:0];
        is_add     = 1'b1;
      end
      default: begin
        case (mm)
          4'd0: begin alu_result = sum_c[31:0]; is_add = 1'b1; end
          4'd1: begin alu_result = dif_c[31:0]; is_sub = 1'b1; end
          4'd2: alu_result = rsa & op_b;
          4'd3: alu_result = rsa | op_b;
          4'd4: alu_result = rsa ^ op_b;
          4'd5: alu_result = ~rsa;
          4'd6: alu_result = rsa << op_b[4:0];
          4'd7: alu_result = rsa >> op_b[4:0];
          default: alu_result = '0;
        endcase
      end
    endcase
    stat_next[3] = is_sub ? dif_c[32] : sum_c[32];
    stat_next[2] = (is_add & (rsa[31] == op_b[31]) & (alu_result[31] != rsa[31])) |
                   (is_sub & (rsa[31] != op_b[31]) & (alu_result[31] != rsa[31]));
    stat_next[1] = alu_result[31];
    stat_next[0] = (alu_result == '0);
  end

  // Branch condition: BRA/BRR on any masked flag (or unconditional), BNE/BNR on none
  always_comb begin
    case (op)
      OP_BRA, OP_BRR: taken = (mm == 4'd0) || ((stat & mm) != 4'd0);
      OP_BNE, OP_BNR: taken = ((stat & mm) == 4'd0);
      default:        taken = 1'b0;
    endcase
  end

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) state <= S_RESET;
    else       state <= state_nxt;
  end

  // Sequencer: HLT parks in EXECUTE, SWP takes an extra writeback cycle
  always_comb begin
    case (state)
      S_RESET:   state_nxt = S_START;
      S_START:   state_nxt = S_FETCH;
      S_FETCH:   state_nxt = S_DECODE;
      S_DECODE:  state_nxt = S_EXECUTE;
      S_EXECUTE: state_nxt = (op == OP_HLT) ? S_EXECUTE : S_MEM;
      S_MEM:     state_nxt = S_WB;
      S_WB:      state_nxt = is_swp ? S_WB2 : S_FETCH;
      default:   state_nxt = S_FETCH;
    endcase
  end

  // Control outputs decoded from state and the current instruction
  always_comb begin
    pc_rst    = 1'b0;
    ir_load   = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = 1'b0;
    br_sel    = 1'b0;
    stat_en   = 1'b0;
    dm_we     = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 2'b00;
    swp_sel   = 1'b1;
    alu_op    = 2'b00;
    mm_sel    = 1'b0;
    rb_sel    = 1'b0;
    in_window = (state == S_EXECUTE) || (state == S_MEM) ||
                (state == S_WB) || (state == S_WB2);
    if (in_window) begin
      if (op == OP_ALUI)  alu_op = 2'b01;
      else if (is_mem)    alu_op = 2'b10;
      else if (is_swp)    alu_op = 2'b11;
      mm_sel = is_mem & mm[0];
      rb_sel = (op == OP_STR) | is_swp;
    end
    case (state)
      S_RESET, S_START: pc_rst = 1'b1;
      S_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        if (taken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          br_sel   = (op == OP_BRA) || (op == OP_BNE);
        end
      end
      S_EXECUTE: stat_en = (op == OP_ALUR) || (op == OP_ALUI);
      S_MEM:     dm_we   = (op == OP_STR);
      S_WB: begin
        if ((op == OP_ALUR) || (op == OP_ALUI)) begin
          rf_we = 1'b1;
        end else if (op == OP_LOD) begin
          rf_we  = 1'b1;
          wb_sel = 2'b01;
        end else if (is_swp) begin
          rf_we  = 1'b1;
          wb_sel = 2'b10;
        end
      end
      S_WB2: begin
        rf_we   = 1'b1;
        wb_sel  = 2'b11;
        swp_sel = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sisc_exec_core.sv
// Testbench for sisc_exec_core: directed cases plus randomized instructions,
// each compared against a behavioural model of the instruction phases.
module tb_sisc_exec_core;

  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] rsa = '0;
  logic [31:0] rsb = '0;
  logic [3:0]  stat = '0;
  logic [15:0] pc_out = '0;
  logic [31:0] alu_result;
  logic [3:0]  stat_next;
  logic        stat_en, rf_we, br_sel, pc_rst, pc_write, pc_sel;
  logic        rb_sel, ir_load, mm_sel, dm_we, swp_sel;
  logic [15:0] br_addr;
  logic [1:0]  alu_op, wb_sel;

`ifdef SISC_SWP_EN
  localparam bit SWP_EN = 1'b1;
`else
  localparam bit SWP_EN = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  sisc_exec_core dut (
    .clk(clk), .rst_f(rst_f), .instr(instr), .rsa(rsa), .rsb(rsb),
    .stat(stat), .pc_out(pc_out), .alu_result(alu_result),
    .stat_next(stat_next), .stat_en(stat_en), .br_addr(br_addr),
    .rf_we(rf_we), .alu_op(alu_op), .wb_sel(wb_sel), .br_sel(br_sel),
    .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel),
    .rb_sel(rb_sel), .ir_load(ir_load), .mm_sel(mm_sel), .dm_we(dm_we),
    .swp_sel(swp_sel)
  );

  always #5 clk = ~clk;

  // {pc_rst, ir_load, pc_write, pc_sel, br_sel, stat_en, dm_we, rf_we, wb_sel}
  logic [9:0] ctl;
  assign ctl = {pc_rst, ir_load, pc_write, pc_sel, br_sel, stat_en, dm_we, rf_we, wb_sel};
  logic [3:0] sel;
  assign sel = {rb_sel, mm_sel, alu_op};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit br_taken(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] st);
    if (op == 4'h6 || op == 4'h7) return (mm == 4'd0) || ((st & mm) != 4'd0);
    if (op == 4'h8 || op == 4'h9) return (st & mm) == 4'd0;
    return 1'b0;
  endfunction

  // Expected enables for phase 0..5 = FETCH, DECODE, EXECUTE, MEM, WB, WB2
  function automatic logic [9:0] exp_ctl(input int ph, input logic [31:0] ins, input logic [3:0] st);
    logic [3:0] op, mm;
    logic [9:0] e;
    bit swp;
    op = ins[31:28];
    mm = ins[27:24];
    swp = SWP_EN && (op == 4'h5);
    e = '0;
    case (ph)
      0: begin e[8] = 1'b1; e[7] = 1'b1; end
      1: if (br_taken(op, mm, st)) begin
           e[7] = 1'b1; e[6] = 1'b1; e[5] = (op == 4'h6) || (op == 4'h8);
         end
      2: e[4] = (op == 4'h1) || (op == 4'h2);
      3: e[3] = (op == 4'h4);
      4: begin
           if (op == 4'h1 || op == 4'h2) e[2] = 1'b1;
           else if (op == 4'h3) begin e[2] = 1'b1; e[1:0] = 2'b01; end
           else if (swp) begin e[2] = 1'b1; e[1:0] = 2'b10; end
         end
      5: begin e[2] = 1'b1; e[1:0] = 2'b11; end
      default: e = '0;
    endcase
    return e;
  endfunction

  // Expected {rb_sel, mm_sel, alu_op} while the instruction executes
  function automatic logic [3:0] exp_sel(input logic [31:0] ins);
    logic [3:0] op;
    bit swp, mem;
    logic [1:0] aop;
    op = ins[31:28];
    swp = SWP_EN && (op == 4'h5);
    mem = (op == 4'h3) || (op == 4'h4);
    aop = 2'b00;
    if (op == 4'h2) aop = 2'b01;
    else if (mem) aop = 2'b10;
    else if (swp) aop = 2'b11;
    return {(op == 4'h4) || swp, mem && ins[24], aop};
  endfunction

  // ALU reference for opcodes 1/2: returns {C,V,N,Z,result}
  function automatic logic [35:0] alu_model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] bv, r;
    longint sa, sb, s;
    longint lim;
    bit c, v;
    lim = 64'sd2147483648;
    bv = (ins[31:28] == 4'h2) ? 32'($signed(ins[15:0])) : b;
    sa = longint'($signed(a));
    sb = longint'($signed(bv));
    c = (64'(a) + 64'(bv)) > 64'hFFFF_FFFF;
    v = 1'b0;
    case (ins[27:24])
      4'd0: begin r = a + bv; s = sa + sb; v = (s > lim - 1) || (s < -lim); end
      4'd1: begin r = a - bv; s = sa - sb; v = (s > lim - 1) || (s < -lim); c = (a >= bv); end
      4'd2: r = a & bv;
      4'd3: r = a | bv;
      4'd4: r = a ^ bv;
      4'd5: r = ~a;
      4'd6: r = a << (bv % 32);
      4'd7: r = a >> (bv % 32);
      default: r = 32'd0;
    endcase
    return {c, v, r[31], r == 32'd0, r};
  endfunction

  // Assert reset, check the reset outputs, release and walk to FETCH
  task automatic do_reset;
    rst_f = 1'b1;
    #1;
    chk("rst_async", 32'(ctl), 32'h200);
    @(negedge clk);
    chk("rst_hold", 32'(ctl), 32'h200);
    rst_f = 1'b0;
    step;
    chk("rst_start", 32'(ctl), 32'h200);
    step;
  endtask

  // Run one instruction starting from a FETCH negedge; returns at the next FETCH
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] st, input logic [15:0] pc);
    logic [3:0] op;
    logic [35:0] m;
    bit swp;
    op = ins[31:28];
    swp = SWP_EN && (op == 4'h5);
    chk("fetch", 32'(ctl), 32'(exp_ctl(0, ins, st)));
    instr = ins; rsa = a; rsb = b; stat = st; pc_out = pc;
    step;
    chk("decode", 32'(ctl), 32'(exp_ctl(1, ins, st)));
    if (br_taken(op, ins[27:24], st))
      chk("br_addr", 32'(br_addr),
          (op == 4'h6 || op == 4'h8) ? 32'(ins[15:0]) : 32'(16'(pc + ins[15:0])));
    step;
    chk("execute", 32'(ctl), 32'(exp_ctl(2, ins, st)));
    chk("sel_ex", 32'(sel), 32'(exp_sel(ins)));
    if (op == 4'h1 || op == 4'h2) begin
      m = alu_model(ins, a, b);
      chk("alu_result", alu_result, m[31:0]);
      chk("flags", 32'(stat_next), 32'(m[35:32]));
    end else if (op == 4'h3 || op == 4'h4) begin
      chk("addr", alu_result, a + {16'h0, ins[15:0]});
    end else if (swp) begin
      chk("pass", alu_result, a);
    end
    if (op == 4'hF) begin
      for (int i = 0; i < 10; i++) begin
        step;
        chk("halt", 32'(ctl), 32'h0);
      end
      return;
    end
    step;
    chk("mem", 32'(ctl), 32'(exp_ctl(3, ins, st)));
    chk("sel_mem", 32'(sel), 32'(exp_sel(ins)));
    step;
    chk("wb", 32'(ctl), 32'(exp_ctl(4, ins, st)));
    chk("sel_wb", 32'(sel), 32'(exp_sel(ins)));
    chk("swp_sel_wb", 32'(swp_sel), 32'd1);
    if (swp) begin
      step;
      chk("wb2", 32'(ctl), 32'(exp_ctl(5, ins, st)));
      chk("sel_wb2", 32'(sel), 32'(exp_sel(ins)));
      chk("swp_sel_wb2", 32'(swp_sel), 32'd0);
    end
    step;
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ins;
    #2;
    do_reset;
    // Directed cases
    run_instr(32'h1000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 4'h0, 16'h0010);
    chk("add_flags_req", 32'(stat_next), 32'h6);
    run_instr(32'h1100_0000, 32'd5, 32'd5, 4'h0, 16'h0020);
    run_instr(32'h7100_FFFE, 32'd0, 32'd0, 4'h1, 16'h0011);
    run_instr(32'h8100_1234, 32'd0, 32'd0, 4'h1, 16'h0030);
    run_instr(32'h6000_4321, 32'd0, 32'd0, 4'h0, 16'h0040);
    run_instr(32'h5120_0000, 32'hAAAA_5555, 32'h1234_5678, 4'h0, 16'h0050);
    run_instr(32'h3100_0080, 32'h0000_1000, 32'd0, 4'h0, 16'h0060);
    run_instr(32'h4000_0080, 32'h0000_1000, 32'd9, 4'h0, 16'h0070);
    run_instr(32'h2000_8000, 32'h0000_0001, 32'd0, 4'h0, 16'h0080);
    // Randomized instructions (HLT excluded; covered separately)
    for (int n = 0; n < 80; n++) begin
      ins = $urandom;
      ins[31:28] = 4'($urandom_range(0, 14));
      run_instr(ins, pick32(), pick32(), 4'($urandom_range(0, 15)), 16'($urandom));
    end
    // Reset in the middle of an ALU instruction: no writeback may follow
    instr = 32'h1000_0000;
    step;
    step;
    do_reset;
    run_instr(32'h1400_0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'h0, 16'h0001);
    // Halt, then recover through reset
    run_instr(32'hF000_0000, 32'd0, 32'd0, 4'h0, 16'h0002);
    do_reset;
    run_instr(32'h1600_0000, 32'h0000_0001, 32'h0000_0023, 4'h0, 16'h0003);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sisc_exec_core.md
SISC_EXEC_CORE -- requirements
Module: sisc_exec_core

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst_f  in  1  reset, asynchronous, active-high.
REQ-004 instr  in  32  IR contents: op=[31:28], mm=[27:24], rd=[23:20], rs=[19:16], rt=[15:12], imm=[15:0].
REQ-005 rsa  in  32  register-file read port A (rs).
REQ-006 rsb  in  32  register-file read port B.
REQ-007 stat  in  4  current status register {C,V,N,Z} = [3:0].
REQ-008 pc_out  in  16  current PC.
REQ-009 alu_result  out  32  ALU result.
REQ-010 stat_next  out  4  ALU flags {C,V,N,Z}.
REQ-011 stat_en  out  1  status-register load enable.
REQ-012 br_addr  out  16  branch target.
REQ-013 rf_we  out  1  register-file write enable.
REQ-014 alu_op  out  2  00 reg-reg, 01 reg-imm, 10 address (rsa+imm), 11 pass rsa.
REQ-015 wb_sel  out  2  writeback source: 00 alu_result, 01 dm_out, 10 rsa, 11 rsb.
REQ-016 br_sel  out  1  1 absolute, 0 relative target.
REQ-017 pc_rst  out  1  PC reset.
REQ-018 pc_write  out  1  PC load enable.
REQ-019 pc_sel  out  1  PC source: 0 PC+1, 1 br_addr.
REQ-020 rb_sel  out  1  read-reg-B select: 0 rt, 1 rd.
REQ-021 ir_load  out  1  IR load enable.
REQ-022 mm_sel  out  1  DM address: 0 alu_result[15:0], 1 imm.
REQ-023 dm_we  out  1  data-memory write enable.
REQ-024 swp_sel  out  1  write-reg select: 1 rd, 0 rs.

Function
REQ-025 ALU is combinational. B = rsb (alu_op 00), sign-extended imm (01), or zero-extended imm (10). Function from mm: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by B[4:0], 7 SHR logical; any other mm gives result 0. alu_op 10 always ADDs; alu_op 11 passes rsa.
REQ-026 Flags: C = carry out of A+B, or of A+~B+1 for SUB; V = signed overflow for ADD/SUB, else 0; N = result[31]; Z = (result == 0).
REQ-027 br_addr = imm when br_sel=1; otherwise pc_out+imm modulo 2^16 (wrap, no flag).
REQ-028 Opcodes:
- 0 NOP, 1 ALU reg, 2 ALU imm.
- 3 LOD rd <- DM[addr]; 4 STR DM[addr] <- rd (rb_sel=1). Address: mm_sel = mm[0], i.e. imm if mm[0]=1, else rsa+imm.
- 5 SWP rd <-> rs.
- 6 BRA abs, 7 BRR rel: taken if mm==0 or (stat & mm) != 0.
- 8 BNE abs, 9 BNR rel: taken if (stat & mm) == 0.
- F HLT; all other opcodes execute as NOP.
REQ-029 FSM sequence is RESET -> START -> FETCH -> DECODE -> EXECUTE -> MEM -> WB -> FETCH, one cycle per state; SWP inserts WB2 after WB.
REQ-030 FETCH: ir_load=1, pc_write=1, pc_sel=0.
REQ-031 DECODE: for a taken branch, pc_write=1, pc_sel=1, br_sel=1 (BRA/BNE) or 0 (BRR/BNR). A relative target is therefore PC+1+imm.
REQ-032 EXECUTE: stat_en=1 for opcodes 1 and 2 only.
REQ-033 MEM: dm_we=1 for STR.
REQ-034 WB:
- ALU ops: rf_we=1, wb_sel=00, swp_sel=1.
- LOD: rf_we=1, wb_sel=01, swp_sel=1.
- SWP: WB does rf_we=1, wb_sel=10, swp_sel=1; WB2 does rf_we=1, wb_sel=11, rb_sel=1, swp_sel=0.
REQ-035 alu_op, mm_sel and rb_sel are held constant from EXECUTE through WB2. Every other enable is 0 outside the states named above.
REQ-036 HLT: the FSM remains in EXECUTE with all enables 0 until reset.

Reset
REQ-037 rst_f=1 forces RESET immediately: pc_rst=1 and every other output enable 0. pc_rst stays 1 through START, and FETCH begins on the second clock after release. Reset asserted mid-instruction aborts it with no write.

Configuration
REQ-038 Macro SISC_SWP_EN. Defined: SWP behaves per REQ-034. Undefined: opcode 5 executes as NOP, WB2 does not exist, and swp_sel is tied to 1.

Verification
REQ-039 Reset then release -> pc_rst=1 for 2 cycles, then ir_load=1 and pc_write=1.
REQ-040 ALU reg ADD, rsa=7FFFFFFF, rsb=1 -> alu_result=80000000 and flags C0 V1 N1 Z0, with stat_en only in EXECUTE and rf_we only in WB.
REQ-041 SUB, rsa=rsb=5 -> alu_result=0 and flags C1 Z1 V0 N0.
REQ-042 BRR with mm=0001, stat=0001, pc_out=0011, imm=FFFE -> br_addr=000F, with pc_sel=1 and pc_write=1 in DECODE.
REQ-043 BNE with mm=0001, stat=0001 -> no pc_write in DECODE.
REQ-044 SWP -> two consecutive rf_we cycles with swp_sel 1 then 0 (macro defined), or none (undefined); HLT -> outputs stay 0 for 10 cycles.
